// File: rtl/alu_dispatch.sv
// Single-entry issue stage feeding the 32-bit ALU: funct3/funct7 decode, operand select,
// registered ALU inputs. Optional forwarding path enabled by the ALU_DISPATCH_FWD_EN macro.
module alu_dispatch #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic             in_is_imm,
  input  logic [4:0]       in_rs1_addr,
  input  logic [4:0]       in_rs2_addr,
  input  logic [4:0]       in_rd,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [3:0]       alu_op,
  output logic [4:0]       out_rd,
  output logic [CNT_W-1:0] evt_cnt
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  alu_op_e         op_d;
  logic [XLEN-1:0] op1_d;
  logic [XLEN-1:0] op2_d;
  logic            haz_rs1;
  logic            haz_rs2;
  logic            accept;
  logic            xfer;
  logic            evt_inc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op_d = OP_ADD;
    unique case (in_funct3)
      3'b000: op_d = (in_funct7b5 && !in_is_imm) ? OP_SUB : OP_ADD;
      3'b001: op_d = OP_SLL;
      3'b010: op_d = OP_SLT;
      3'b011: op_d = OP_SLTU;
      3'b100: op_d = OP_XOR;
      3'b101: op_d = in_funct7b5 ? OP_SRA : OP_SRL;
      3'b110: op_d = OP_OR;
      3'b111: op_d = OP_AND;
      default: op_d = OP_ADD;
    endcase
  end

  // x0 is hardwired zero, so a pending write to it never creates a dependency.
  assign haz_rs1 = out_valid && (out_rd != 5'd0) && (in_rs1_addr == out_rd);
  assign haz_rs2 = out_valid && (out_rd != 5'd0) && !in_is_imm && (in_rs2_addr == out_rd);
  assign xfer    = out_valid && out_ready;
  assign accept  = in_valid && in_ready;

`ifdef ALU_DISPATCH_FWD_EN
  logic [XLEN-1:0] rs2_val;

  // alu_result always belongs to the entry held now, i.e. the producer of out_rd.
  assign op1_d    = haz_rs1 ? alu_result : in_rs1_data;
  assign rs2_val  = haz_rs2 ? alu_result : in_rs2_data;
  assign op2_d    = in_is_imm ? in_imm : rs2_val;
  assign in_ready = !out_valid || out_ready;
  assign evt_inc  = accept && (haz_rs1 || haz_rs2);
`else
  logic unused_alu_result;

  assign unused_alu_result = ^alu_result;
  assign op1_d    = in_rs1_data;
  assign op2_d    = in_is_imm ? in_imm : in_rs2_data;
  // Hold a dependent instruction off until the producer has left; the register file
  // then supplies the written value one cycle later.
  assign in_ready = (!out_valid || out_ready) && !(in_valid && (haz_rs1 || haz_rs2));
  assign evt_inc  = in_valid && (haz_rs1 || haz_rs2);
`endif

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      alu_op    <= OP_ADD;
      out_rd    <= '0;
      evt_cnt   <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        op1       <= op1_d;
        op2       <= op2_d;
        alu_op    <= op_d;
        out_rd    <= in_rd;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (evt_inc && (evt_cnt != '1)) begin
        evt_cnt <= evt_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Single-entry issue stage directly upstream of the 32-bit ALU. Accepts decoded integer instructions over a valid/ready handshake and translates RISC-V funct3/funct7 fields into the ALU's 4-bit `alu_op`. Selects register or immediate operands, forwards the ALU's combinational result into an immediately dependent instruction, and holds `op1`/`op2`/`alu_op` stable in a pipeline register that drives the ALU inputs.

## Interface
- `XLEN`, 32: operand width.
- `CNT_W`, 16: width of the hazard/forward event counter.

- `clk` in 1: clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: stage can accept this cycle.
- `in_funct3` in 3: RISC-V funct3.
- `in_funct7b5` in 1: instruction bit 30.
- `in_is_imm` in 1: 1 = OP-IMM form, op2 from `in_imm`.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd` in 5 each: register indices.
- `in_rs1_data`, `in_rs2_data`, `in_imm` in XLEN each: register-file read data and sign-extended immediate.
- `alu_result` in XLEN: ALU combinational result for the entry currently held.
- `out_valid` out 1: held entry valid.
- `out_ready` in 1: downstream (ALU/writeback) consumes entry.
- `op1`, `op2` out XLEN: ALU operands (registered).
- `alu_op` out 4: ALU opcode (registered).
- `out_rd` out 5: destination of held entry.
- `evt_cnt` out CNT_W: saturating count of forward (or stall) events.

## Operation
- Decode, funct3 → alu_op:
  - 000 → ADD 0000, or SUB 0001 when `in_funct7b5`=1 and `in_is_imm`=0 (ADDI never SUB).
  - 001 → SLL 0101.
  - 010 → SLT 1000.
  - 011 → SLTU 1001.
  - 100 → XOR 0100.
  - 101 → SRL 0110, or SRA 0111 when `in_funct7b5`=1 (both forms).
  - 110 → OR 0011.
  - 111 → AND 0010.
- Operands: op1 = rs1 value; op2 = `in_is_imm` ? `in_imm` : rs2 value. Immediates are passed through unmodified; the ALU uses only bits [4:0] for shifts.
- Forwarding: a source is hazardous when `out_valid`=1, its address equals `out_rd`, and `out_rd`≠0. For rs2 this applies only when `in_is_imm`=0.
  - With forwarding, hazardous source data = `alu_result`.
  - Register x0 (address 0) is never forwarded.
- `evt_cnt` increments by 1 per accepted instruction with at least one forwarded source (or per stall cycle, see Configuration). Saturates at all-ones with no wrap.

## Timing
- Accept = `in_valid & in_ready`. Transfer out = `out_valid & out_ready`.
- `in_ready` = `!out_valid | out_ready`, or 0 on a hazard stall when forwarding is compiled out.
- Latency: instruction accepted in cycle N appears on `op1`/`op2`/`alu_op`/`out_rd` with `out_valid`=1 in cycle N+1.
- Full throughput: one instruction per cycle while `out_ready`=1.
- Simultaneous transfer-out and accept: the register loads the new entry and `out_valid` stays 1. Forwarding uses the `alu_result` of the departing entry.
- Transfer out with no accept: `out_valid`→0. Data registers may hold stale values.
- Backpressure (`out_valid`=1, `out_ready`=0): all outputs held bit-stable; `in_ready`=0.
- Reset (`rst_n`=0 at an edge, including mid-stream): `out_valid`=0, `op1`=0, `op2`=0, `alu_op`=0000, `out_rd`=0, `evt_cnt`=0. The held entry is discarded. `in_ready`=1 from the first cycle after reset.

## Configuration
- `ALU_DISPATCH_FWD_EN` defined: forwarding mux present; `evt_cnt` counts forward events.
- Not defined: no forwarding path and `alu_result` is unused. A hazardous instruction forces `in_ready`=0 until the held entry leaves (`out_valid`=0). It is then accepted with register-file data, costing one bubble. `evt_cnt` counts stall cycles.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `alu_op`=0, `evt_cnt`=0, `in_ready`=1 after release.
- Decode sweep: funct3 000..111 with funct7b5 0/1 and is_imm 0/1 → alu_op matches the table. funct3=000, funct7b5=1, is_imm=1 → 0000; funct3=101, funct7b5=1, is_imm=1 → 0111.
- Immediate: is_imm=1, rs1_data=5, rs2_data=9, imm=0xFFFFFFFC → op1=5, op2=0xFFFFFFFC one cycle later.
- Forward (FWD_EN): ADD rd=3 held with `alu_result`=0x1234, `out_ready`=1; next instruction rs1=3, rs2=3, is_imm=0, stale rs data 0 → op1=op2=0x1234, `evt_cnt`=1. Same sequence with rd=0 → no forward, op1=0, `evt_cnt` unchanged.
- Backpressure: `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0, outputs unchanged. Release → one transfer; the pending instruction is accepted in the same cycle.
- Without FWD_EN: the dependent sequence above → `in_ready`=0 for 1 cycle, then op1 = rs1_data, `evt_cnt`=1. `evt_cnt` preloaded to 0xFFFF saturates at 0xFFFF.
